vram_scan_arbiter: RTL and testbench

Sequences accesses to the single-port, 64 KiB byte-wide video RAM and shares it between display scan-out and a CPU-side requester. Driven by the VGA timing counters, it fetches one 1bpp pattern byte per 8-pixel tile column ahead of the beam, serialises it into a per-pixel output, and grants all remaining RAM cycles to the CPU port through a req/ack handshake. It sits between the VGA timing generator, the VRAM and the CPU/PPU register interface.

---
 rtl/vram_scan_arbiter_if.sv | 24 ++
 rtl/vram_scan_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_scan_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_scan_arbiter_if.sv
// CPU request port and VRAM port of the scan arbiter, bundled for the module boundary.
// The arbiter takes the slave view; the CPU/RAM side takes the master view.
interface vram_scan_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares the single-port VRAM between tile-pattern fetch for scan-out and a CPU req/ack port.
// Display fetches are issued ahead of the beam; every other RAM cycle goes to the CPU.
//
// state    | meaning
// IDLE     | RAM free, nothing pending
// DISP_RD  | fetch address on the RAM bus
// DISP_CAP | pattern byte captured into fetch_buf on entry
// CPU_ACC  | CPU address/data/we on the RAM bus
// CPU_CAP  | cpu_ack high, read data captured on entry
module vram_scan_arbiter #(
    parameter int ACT_COLS  = 32,
    parameter int ACT_LINES = 240,
    parameter int LAST_COL  = 99,
    parameter int LAST_LINE = 524
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  pix_ce,
    input  logic [9:0]            hc,
    input  logic [9:0]            vc,
    output logic                  pixel,
    output logic                  fetch_late,
    vram_scan_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, DISP_RD, DISP_CAP, CPU_ACC, CPU_CAP} state_t;

    state_t      state;
    logic [7:0]  fetch_buf;
    logic [7:0]  shreg;
    logic [15:0] fetch_addr;
    logic        fetch_pend;

    logic [6:0]  tile;
    logic [6:0]  tgt_col;
    logic [9:0]  tgt_line;
    logic        tgt_valid;
    logic [15:0] tgt_addr;
    logic        trig;
    logic        fetch_now;
    logic        load;
    logic        go_disp;

    assign tile = hc[9:3];

    // Target is the next tile column; after the last column it wraps to column 0 of the next line.
    always_comb begin
        tgt_col  = 7'd0;
        tgt_line = 10'd0;
        if (tile < 7'(LAST_COL)) begin
            tgt_col  = tile + 7'd1;
            tgt_line = vc;
        end else begin
            tgt_col  = 7'd0;
            tgt_line = (vc == 10'(LAST_LINE)) ? 10'd0 : vc + 10'd1;
        end
        tgt_valid = (tgt_col < 7'(ACT_COLS)) && (tgt_line < 10'(ACT_LINES));
        tgt_addr  = 16'({tgt_line[9:3], 8'd0}) + 16'({tgt_col, 4'd0}) + 16'(tgt_line[2:0]);
    end

    assign trig      = pix_ce && (hc[2:0] == 3'd4);
    assign fetch_now = trig && tgt_valid;
    assign load      = pix_ce && (hc[2:0] == 3'd7);
    assign go_disp   = fetch_pend || fetch_now;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            fetch_pend    <= 1'b0;
            fetch_addr    <= 16'd0;
            fetch_buf     <= 8'd0;
            bus.ram_addr  <= 16'd0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= 8'd0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= 8'd0;
        end else begin
            bus.cpu_ack <= 1'b0;
            if (fetch_now) begin
                fetch_addr <= tgt_addr;
                fetch_pend <= 1'b1;
            end else if (trig) begin
                fetch_buf <= 8'd0;
            end
            case (state)
                IDLE, DISP_CAP, CPU_CAP: begin
                    if (go_disp) begin
                        state        <= DISP_RD;
                        bus.ram_addr <= fetch_now ? tgt_addr : fetch_addr;
                        bus.ram_we   <= 1'b0;
                        fetch_pend   <= 1'b0;
                    end else if (bus.cpu_req) begin
                        state         <= CPU_ACC;
                        bus.ram_addr  <= bus.cpu_addr;
                        bus.ram_we    <= bus.cpu_we;
                        bus.ram_wdata <= bus.cpu_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                DISP_RD: begin
                    state     <= DISP_CAP;
                    fetch_buf <= bus.ram_rdata;
                end
                CPU_ACC: begin
                    // ram_we still holds this access's direction, so it selects the capture.
                    state       <= CPU_CAP;
                    bus.ram_we  <= 1'b0;
                    bus.cpu_ack <= 1'b1;
                    if (!bus.ram_we)
                        bus.cpu_rdata <= bus.ram_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shreg      <= 8'd0;
            fetch_late <= 1'b0;
        end else if (pix_ce) begin
            if (load)
                shreg <= fetch_buf;
            else
                shreg <= {1'b0, shreg[7:1]};
            if (load && (fetch_pend || state == DISP_RD))
                fetch_late <= 1'b1;
        end
    end

    assign pixel = shreg[0];

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter: reset behaviour, fetch addressing, pixel order,
// CPU arbitration latency, back-to-back CPU reads under scan-out, and the late-fetch flag.
module tb_vram_scan_arbiter;
    logic       Clk;
    logic       Reset;
    logic       pix_ce;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pixel;
    logic       fetch_late;

    vram_scan_arbiter_if bus();

    vram_scan_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .pix_ce     (pix_ce),
        .hc         (hc),
        .vc         (vc),
        .pixel      (pixel),
        .fetch_late (fetch_late),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt;
    int rec_line;
    logic pix_rec [0:799];
    logic scan_done;

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_init(input logic [15:0] a);
        case (a)
            16'h0000: return 8'hA5;
            16'h0010: return 8'h3C;
            16'h0006: return 8'h81;
            16'h0055: return 8'h77;
            default:  return pat(a);
        endcase
    endfunction

    // VRAM model: read data follows the registered address within the cycle, writes land on the edge.
    logic [7:0] mem [0:65535];
    logic loaded = 1'b0;
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge Clk) begin
        if (!loaded) begin
            for (int a = 0; a < 65536; a++)
                mem[a] <= ram_init(16'(a));
            loaded <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        we_cnt = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.ram_we) we_cnt++;
            if (bus.cpu_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic trig_at(input string tag, input int v, input int h, input logic [15:0] exp);
        vc = 10'(v);
        hc = 10'(h);
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        chk(tag, bus.ram_addr, exp);
        repeat (3) tick();
    endtask

    task automatic scan(input int v0, input int h0, input int npix);
        vc = 10'(v0);
        hc = 10'(h0);
        for (int i = 0; i < npix; i++) begin
            pix_ce = 1'b1;
            tick();
            pix_ce = 1'b0;
            if (hc == 10'd799) begin
                hc = 10'd0;
                vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
            end else begin
                hc = hc + 10'd1;
            end
            if (vc == 10'(rec_line)) pix_rec[hc] = pixel;
            tick();
        end
    endtask

    function automatic logic [7:0] pack8(input int base);
        logic [7:0] b;
        for (int n = 0; n < 8; n++) b[n] = pix_rec[base + n];
        return b;
    endfunction

    initial begin
        int n;
        int nacc;
        logic stop;
        logic [15:0] addr;
        logic [15:0] cur;

        Reset = 1'b1;
        pix_ce = 1'b0;
        hc = 10'd0;
        vc = 10'd300;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'd0;
        bus.cpu_wdata = 8'd0;
        rec_line = 1000;
        scan_done = 1'b0;
        repeat (3) tick();

        chk("rst_ram_addr", bus.ram_addr, 16'h0000);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        chk("rst_ram_wdata", bus.ram_wdata, 8'h00);
        chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        chk("rst_pixel", pixel, 1'b0);
        chk("rst_fetch_late", fetch_late, 1'b0);
        Reset = 1'b0;
        tick();

        // Write interrupted by reset; the held request must be served afresh.
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h1234;
        bus.cpu_wdata = 8'h5A;
        tick();
        chk("acc_ram_we", bus.ram_we, 1'b1);
        chk("acc_ram_addr", bus.ram_addr, 16'h1234);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ram_we", bus.ram_we, 1'b0);
        chk("mid_rst_ram_addr", bus.ram_addr, 16'h0000);
        chk("mid_rst_ram_wdata", bus.ram_wdata, 8'h00);
        tick();
        chk("mid_rst_ack", bus.cpu_ack, 1'b0);
        chk("no_write_in_rst", mem[16'h1234], 8'h7C);
        Reset = 1'b0;
        wait_ack(8, n);
        chk("reissue_ack_lat", n, 2);
        bus.cpu_req = 1'b0;
        tick();
        chk("reissue_mem", mem[16'h1234], 8'h5A);

        // Fetch addresses: (line>>3)<<8 + col<<4 + line[2:0].
        trig_at("addr_frame_wrap", 524, 796, 16'h0000);
        trig_at("addr_l100_c2", 100, 12, 16'h0C24);
        trig_at("addr_l239_c31", 239, 244, 16'h1EF7); // (29<<8)+(31<<4)+7
        trig_at("addr_l6_c0", 5, 796, 16'h0006);

        // Line 240 is outside the active area: no RAM read, blank pixels.
        rec_line = 240;
        scan(239, 792, 24);
        chk("l240_px_0_7", pack8(0), 8'h00);
        chk("l240_px_8_15", pack8(8), 8'h00);
        chk("l240_no_ram_rd", bus.ram_addr, 16'h0006);

        // Line 0 from the end of the previous frame: 0xA5 then 0x3C, LSB first.
        rec_line = 0;
        scan(524, 792, 32);
        chk("l0_px_0_7", pack8(0), 8'hA5);
        chk("l0_px_8_15", pack8(8), 8'h3C);
        chk("l0_px_16_23", pack8(16), 8'h7A);
        chk("l0_late", fetch_late, 1'b0);
        repeat (3) tick();

        // Trigger and CPU read in the same idle cycle: display goes first.
        vc = 10'd2;
        hc = 10'd4;
        pix_ce = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0055;
        tick();
        pix_ce = 1'b0;
        chk("simul_first_addr", bus.ram_addr, 16'h0012);
        chk("simul_first_we", bus.ram_we, 1'b0);
        wait_ack(10, n);
        chk("simul_ack_lat", n + 1, 4);
        chk("simul_rdata", bus.cpu_rdata, 8'h77);
        bus.cpu_req = 1'b0;
        tick();
        chk("simul_late", fetch_late, 1'b0);
        repeat (2) tick();

        // Back-to-back CPU reads while line 0 scans out.
        nacc = 0;
        stop = 1'b0;
        addr = 16'h4000;
        rec_line = 0;
        scan_done = 1'b0;
        fork
            begin
                scan(0, 0, 64);
                scan_done = 1'b1;
            end
            begin
                bus.cpu_we = 1'b0;
                bus.cpu_addr = addr;
                bus.cpu_req = 1'b1;
                for (int k = 0; k < 400 && !stop; k++) begin
                    tick();
                    if (bus.cpu_ack) begin
                        cur = bus.cpu_addr;
                        chk("bb_rdata", bus.cpu_rdata, pat(cur));
                        nacc++;
                        if (scan_done) begin
                            bus.cpu_req = 1'b0;
                            stop = 1'b1;
                        end else begin
                            addr = addr + 16'd3;
                            bus.cpu_addr = addr;
                        end
                    end
                end
            end
        join
        chk("bb_done", stop, 1'b1);
        chk("bb_rate_ge48", (nacc >= 48), 1'b1);
        chk("bb_px_8_15", pack8(8), 8'h3C);
        chk("bb_px_16_23", pack8(16), 8'h7A);
        chk("bb_late", fetch_late, 1'b0);
        repeat (3) tick();

        // Write 0xFFFF, read it back, then confirm read data survives an intervening write.
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'hFFFF;
        bus.cpu_wdata = 8'hC3;
        wait_ack(8, n);
        chk("wr_ack_lat", n, 2);
        chk("wr_we_cycles", we_cnt, 1);
        bus.cpu_req = 1'b0;
        tick();
        chk("wr_ack_pulse", bus.cpu_ack, 1'b0);
        chk("wr_mem", mem[16'hFFFF], 8'hC3);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        wait_ack(8, n);
        chk("rd_ack_lat", n, 2);
        chk("rd_ffff", bus.cpu_rdata, 8'hC3);
        bus.cpu_req = 1'b0;
        tick();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h4001;
        bus.cpu_wdata = 8'h11;
        wait_ack(8, n);
        chk("rdata_hold", bus.cpu_rdata, 8'hC3);
        bus.cpu_req = 1'b0;
        repeat (2) tick();

        // Illegal strobe spacing: tile load while the fetch is still on the bus.
        vc = 10'd0;
        hc = 10'd4;
        pix_ce = 1'b1;
        tick();
        hc = 10'd7;
        tick();
        pix_ce = 1'b0;
        chk("late_set", fetch_late, 1'b1);
        repeat (4) tick();
        chk("late_sticky", fetch_late, 1'b1);
        Reset = 1'b1;
        #1;
        chk("late_rst", fetch_late, 1'b0);
        tick();
        Reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
